ysyx_23060236_axi_arbiter: RTL and testbench
============================================

# ysyx_23060236_axi_arbiter

Two-master AXI4 arbiter that shares the single core memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write). It sits between the IFU/LSU and the MMU's virtual-side `v_io_master_*` port. It serialises the two masters onto one bus with at most one outstanding transaction. Grants are round-robin, and a grant is held from address acceptance until the final response.

## Interface
- `IFU_ID`, default 4'd0: ARID driven for IFU reads.
- `LSU_ID`, default 4'd1: ARID/AWID driven for LSU transactions.
- `clock`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low (asserted at 0).
- IFU read address: `ifu_arvalid` in 1, `ifu_arready` out 1, `ifu_araddr` in 32, `ifu_arlen` in 8, `ifu_arsize` in 3, `ifu_arburst` in 2.
- IFU read data: `ifu_rvalid` out 1, `ifu_rready` in 1, `ifu_rdata` out 32, `ifu_rresp` out 2, `ifu_rlast` out 1.
- LSU read address and data: `lsu_ar*` and `lsu_r*`, identical to the IFU set.
- LSU write address: `lsu_awvalid` in 1, `lsu_awready` out 1, `lsu_awaddr` in 32, `lsu_awlen` in 8, `lsu_awsize` in 3, `lsu_awburst` in 2.
- LSU write data: `lsu_wvalid` in 1, `lsu_wready` out 1, `lsu_wdata` in 32, `lsu_wstrb` in 4, `lsu_wlast` in 1.
- LSU write response: `lsu_bvalid` out 1, `lsu_bready` in 1, `lsu_bresp` out 2.
- Downstream port: the full AXI4 master set `io_master_aw*/w*/b*/ar*/r*`, with the same names, widths and directions as the MMU virtual-side port. It connects to the MMU `v_io_master_*` inputs.

## Operation
- FSM states: IDLE, RD_AR, RD_R, WR, WR_B. Register `owner` (IFU/LSU) and register `last_lsu`.
- IDLE, candidate requests:
  - IFU requests when `ifu_arvalid` is high.
  - LSU requests when `lsu_awvalid | lsu_arvalid` is high; AW is preferred when both are high.
- IDLE, arbitration:
  - With one requester, it wins.
  - With both, the winner is IFU if `last_lsu`=1, else LSU.
- IDLE, on a grant:
  - Assert the winner's `arready` or `awready` combinationally in the same cycle.
  - Latch addr/len/size/burst and the ID into output registers.
  - Set `owner`; set `last_lsu` to (winner==LSU).
  - Go to RD_AR, or to WR for an LSU AW.
- RD_AR: `io_master_arvalid`=1 from the registers. On `io_master_arready`, go to RD_R.
- RD_R: forward R combinationally between the downstream port and `owner`. The non-owner's `rvalid` is 0. On `io_master_rvalid & rready & rlast`, go to IDLE.
- WR, AW and W channels:
  - `io_master_awvalid` is registered and held until `awready`; `aw_done` is then set.
  - W is forwarded combinationally from the LSU; it is blocked (`wvalid`/`wready` = 0) once `w_done` is set.
  - `w_done` is set on a W handshake with `wlast`.
- WR, exit: when both `aw_done` and `w_done` are set, or are being set this cycle, go to WR_B.
- WR_B: forward B to the LSU. On `bvalid & bready`, go to IDLE.
- `io_master_bready`/`rready` are 0 outside WR_B/RD_R.
- `rresp`/`bresp`/`rdata` are forwarded unchanged. Errors do not alter sequencing.
- `io_master_rid`/`bid` are ignored for routing; routing uses `owner`.

## Timing
- Reset values:
  - State IDLE, `last_lsu`=1 (IFU wins the first tie), `owner`=IFU, `aw_done`=`w_done`=0.
  - All address registers 0.
  - Every valid/ready output is 0, except the IDLE combinational `arready`/`awready` grant, which is gated by requests.
- Read latency: the requester's AR handshake in cycle 0 gives `io_master_arvalid` in cycle 1. With `arready` in cycle 1, R data can pass through from cycle 2 with zero added latency.
- Turnaround: the last beat in cycle k gives IDLE in k+1. A new grant is possible in k+1, so there is one bubble cycle per transaction.
- Simultaneous AW and W: both may handshake in the same cycle, and the FSM goes directly to WR_B.
- W before AW: W beats may complete while AW is still pending; the FSM waits in WR.
- A requester deasserting `arvalid` before its grant is legal and is not latched.
- Asynchronous reset mid-transaction drops to IDLE immediately. The transaction is abandoned with no completion response.

## Structure
- Package `ysyx_23060236_axi_pkg` holds:
  - the FSM state encoding;
  - the owner encoding;
  - the default IDs;
  - the AXI burst constant (INCR=2'b01) and the response codes (OKAY=0, SLVERR=2).
- Sub-module `ysyx_23060236_rr_arbiter2`: a 2-way round-robin pick from two request bits plus `last_lsu`.

## Test plan
- Lone IFU read: `ifu_araddr`=0x3000_0000, len 0, `io_master_arready` held 1, `rdata`=0x0000_0413 → `io_master_arid`=0 and `araddr`=0x3000_0000 in cycle 1; `ifu_rdata`=0x0000_0413 in cycle 2; `lsu_rvalid` stays 0.
- Tie: IFU and LSU AR in the same cycle after reset → IFU granted first and LSU second. A repeated tie then goes IFU, LSU, alternating.
- LSU write: AW 0x8000_0010, `wdata` 0xDEAD_BEEF, `wstrb` 0xF. W accepted 2 cycles before `awready` → a single AW and W downstream; `lsu_bvalid` with `bresp` 0 only after `io_master_bvalid`.
- IFU burst: `arlen`=3, 4 beats with an `rready` stall on beat 2 → all 4 beats delivered in order; IDLE the cycle after the `rlast` handshake; a pending LSU AR is granted then.
- Error pass-through: `io_master_rresp`=2 on an LSU read → `lsu_rresp`=2; the FSM returns to IDLE normally.
- Reset asserted during RD_R → all valids low asynchronously; after release, a new IFU read completes normally.

Source files
------------

// File: rtl/ysyx_23060236_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_axi_pkg
// Shared definitions for the IFU/LSU -> MMU AXI4 arbiter:
//   - arb_state_e : arbiter FSM state encoding
//   - owner_e     : which master currently owns the downstream port
//   - default AXI IDs for the IFU and LSU masters
//   - AXI burst / response code constants
// ---------------------------------------------------------------------------
package ysyx_23060236_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_AR = 3'd1,
    ST_RD_R  = 3'd2,
    ST_WR    = 3'd3,
    ST_WR_B  = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

  localparam logic [3:0] IFU_ID_DEFAULT = 4'd0;
  localparam logic [3:0] LSU_ID_DEFAULT = 4'd1;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_23060236_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_rr_arbiter2
// Two-way round-robin pick between the IFU and the LSU.
// Ports:
//   req_ifu_i  - IFU has a pending request
//   req_lsu_i  - LSU has a pending request
//   last_lsu_i - the previous grant went to the LSU
//   gnt_ifu_o  - IFU wins this cycle
//   gnt_lsu_o  - LSU wins this cycle
// A lone requester always wins; on a tie the master that was not served
// last wins. At most one grant is ever asserted.
// ---------------------------------------------------------------------------
module ysyx_23060236_rr_arbiter2 (
  input  logic req_ifu_i,
  input  logic req_lsu_i,
  input  logic last_lsu_i,
  output logic gnt_ifu_o,
  output logic gnt_lsu_o
);

  assign gnt_ifu_o = req_ifu_i & (~req_lsu_i | last_lsu_i);
  assign gnt_lsu_o = req_lsu_i & (~req_ifu_i | ~last_lsu_i);

endmodule

// File: rtl/ysyx_23060236_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_axi_arbiter
// Shares the single core memory port between the IFU (read only) and the
// LSU (read and write). One transaction is outstanding at a time; the grant
// is round-robin and is held from address acceptance until the last
// response (R with rlast, or B).
// Ports:
//   clock, reset          - clock; asynchronous active-low reset
//   ifu_ar*/ifu_r*        - IFU read address / read data channels
//   lsu_ar*/lsu_r*        - LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b* - LSU write address / data / response channels
//   io_master_*           - downstream AXI4 master port (to MMU v_io_master)
// Address/len/size/burst/ID are captured into registers at the grant and
// driven downstream from those registers; data and responses pass through
// combinationally and are routed by the owner register, not by RID/BID.
// ---------------------------------------------------------------------------
module ysyx_23060236_axi_arbiter
  import ysyx_23060236_axi_pkg::*;
#(
  parameter logic [3:0] IFU_ID = IFU_ID_DEFAULT,
  parameter logic [3:0] LSU_ID = LSU_ID_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  // IFU read address / data
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [31:0] ifu_araddr,
  input  logic [7:0]  ifu_arlen,
  input  logic [2:0]  ifu_arsize,
  input  logic [1:0]  ifu_arburst,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rlast,
  // LSU read address / data
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  input  logic [31:0] lsu_araddr,
  input  logic [7:0]  lsu_arlen,
  input  logic [2:0]  lsu_arsize,
  input  logic [1:0]  lsu_arburst,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rlast,
  // LSU write address / data / response
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_awaddr,
  input  logic [7:0]  lsu_awlen,
  input  logic [2:0]  lsu_awsize,
  input  logic [1:0]  lsu_awburst,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic        lsu_wlast,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  output logic [1:0]  lsu_bresp,
  // Downstream AXI4 master
  input  logic        io_master_awready,
  output logic        io_master_awvalid,
  output logic [3:0]  io_master_awid,
  output logic [31:0] io_master_awaddr,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  input  logic        io_master_wready,
  output logic        io_master_wvalid,
  output logic [31:0] io_master_wdata,
  output logic [3:0]  io_master_wstrb,
  output logic        io_master_wlast,
  output logic        io_master_bready,
  input  logic        io_master_bvalid,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [3:0]  io_master_arid,
  output logic [31:0] io_master_araddr,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [31:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        last_lsu_q, last_lsu_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  // One address set serves both AR and AW: only one transaction is live.
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  id_q, id_d;

  logic        ifu_req, lsu_req;
  logic        gnt_ifu, gnt_lsu;
  logic        aw_fire, w_last_fire;

  // Response IDs are not needed: the owner register already knows the target.
  logic        unused_ids;
  assign unused_ids = ^{io_master_rid, io_master_bid};

  assign ifu_req = ifu_arvalid;
  assign lsu_req = lsu_awvalid | lsu_arvalid;

  ysyx_23060236_rr_arbiter2 u_rr (
    .req_ifu_i  (ifu_req),
    .req_lsu_i  (lsu_req),
    .last_lsu_i (last_lsu_q),
    .gnt_ifu_o  (gnt_ifu),
    .gnt_lsu_o  (gnt_lsu)
  );

  // Address-side outputs come straight from the capture registers.
  assign io_master_araddr  = addr_q;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = burst_q;
  assign io_master_arid    = id_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_awlen   = len_q;
  assign io_master_awsize  = size_q;
  assign io_master_awburst = burst_q;
  assign io_master_awid    = id_q;

  // Payload pass-through; validity is controlled in the FSM below.
  assign io_master_wdata = lsu_wdata;
  assign io_master_wstrb = lsu_wstrb;
  assign io_master_wlast = lsu_wlast;
  assign ifu_rdata       = io_master_rdata;
  assign ifu_rresp       = io_master_rresp;
  assign ifu_rlast       = io_master_rlast;
  assign lsu_rdata       = io_master_rdata;
  assign lsu_rresp       = io_master_rresp;
  assign lsu_rlast       = io_master_rlast;
  assign lsu_bresp       = io_master_bresp;

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_lsu_d        = last_lsu_q;
    aw_done_d         = aw_done_q;
    w_done_d          = w_done_q;
    addr_d            = addr_q;
    len_d             = len_q;
    size_d            = size_q;
    burst_d           = burst_q;
    id_d              = id_q;
    aw_fire           = 1'b0;
    w_last_fire       = 1'b0;
    ifu_arready       = 1'b0;
    lsu_arready       = 1'b0;
    lsu_awready       = 1'b0;
    ifu_rvalid        = 1'b0;
    lsu_rvalid        = 1'b0;
    lsu_wready        = 1'b0;
    lsu_bvalid        = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_wvalid  = 1'b0;
    io_master_bready  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_ifu) begin
          ifu_arready = 1'b1;
          addr_d      = ifu_araddr;
          len_d       = ifu_arlen;
          size_d      = ifu_arsize;
          burst_d     = ifu_arburst;
          id_d        = IFU_ID;
          owner_d     = OWNER_IFU;
          last_lsu_d  = 1'b0;
          state_d     = ST_RD_AR;
        end else if (gnt_lsu) begin
          id_d       = LSU_ID;
          owner_d    = OWNER_LSU;
          last_lsu_d = 1'b1;
          // A pending write takes precedence over a pending LSU read.
          if (lsu_awvalid) begin
            lsu_awready = 1'b1;
            addr_d      = lsu_awaddr;
            len_d       = lsu_awlen;
            size_d      = lsu_awsize;
            burst_d     = lsu_awburst;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
            state_d     = ST_WR;
          end else begin
            lsu_arready = 1'b1;
            addr_d      = lsu_araddr;
            len_d       = lsu_arlen;
            size_d      = lsu_arsize;
            burst_d     = lsu_arburst;
            state_d     = ST_RD_AR;
          end
        end
      end

      ST_RD_AR: begin
        io_master_arvalid = 1'b1;
        if (io_master_arready) begin
          state_d = ST_RD_R;
        end
      end

      ST_RD_R: begin
        if (owner_q == OWNER_IFU) begin
          ifu_rvalid       = io_master_rvalid;
          io_master_rready = ifu_rready;
        end else begin
          lsu_rvalid       = io_master_rvalid;
          io_master_rready = lsu_rready;
        end
        if (io_master_rvalid && io_master_rready && io_master_rlast) begin
          state_d = ST_IDLE;
        end
      end

      ST_WR: begin
        // AW and W progress independently; W is cut off after its last beat.
        io_master_awvalid = ~aw_done_q;
        io_master_wvalid  = lsu_wvalid & ~w_done_q;
        lsu_wready        = io_master_wready & ~w_done_q;
        aw_fire           = ~aw_done_q & io_master_awready;
        w_last_fire       = ~w_done_q & lsu_wvalid & io_master_wready & lsu_wlast;
        if (aw_fire) begin
          aw_done_d = 1'b1;
        end
        if (w_last_fire) begin
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_fire) && (w_done_q | w_last_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_B;
        end
      end

      ST_WR_B: begin
        lsu_bvalid       = io_master_bvalid;
        io_master_bready = lsu_bready;
        if (io_master_bvalid && lsu_bready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_IFU;
      last_lsu_q <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      addr_q     <= 32'd0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      id_q       <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_lsu_q <= last_lsu_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      id_q       <= id_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_axi_arbiter.sv
module tb_ysyx_23060236_axi_arbiter;

  logic        clock, reset;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_araddr;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic [1:0]  ifu_arburst;
  logic        ifu_rvalid, ifu_rready, ifu_rlast;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_araddr;
  logic [7:0]  lsu_arlen;
  logic [2:0]  lsu_arsize;
  logic [1:0]  lsu_arburst;
  logic        lsu_rvalid, lsu_rready, lsu_rlast;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_awvalid, lsu_awready;
  logic [31:0] lsu_awaddr;
  logic [7:0]  lsu_awlen;
  logic [2:0]  lsu_awsize;
  logic [1:0]  lsu_awburst;
  logic        lsu_wvalid, lsu_wready, lsu_wlast;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_bvalid, lsu_bready;
  logic [1:0]  lsu_bresp;
  logic        io_master_awready, io_master_awvalid;
  logic [3:0]  io_master_awid;
  logic [31:0] io_master_awaddr;
  logic [7:0]  io_master_awlen;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst;
  logic        io_master_wready, io_master_wvalid, io_master_wlast;
  logic [31:0] io_master_wdata;
  logic [3:0]  io_master_wstrb;
  logic        io_master_bready, io_master_bvalid;
  logic [1:0]  io_master_bresp;
  logic [3:0]  io_master_bid;
  logic        io_master_arready, io_master_arvalid;
  logic [3:0]  io_master_arid;
  logic [31:0] io_master_araddr;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_rready, io_master_rvalid, io_master_rlast;
  logic [1:0]  io_master_rresp;
  logic [31:0] io_master_rdata;
  logic [3:0]  io_master_rid;

  int checks   = 0;
  int failures = 0;
  int aw_cnt   = 0;
  int w_cnt    = 0;

  ysyx_23060236_axi_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
    .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
    .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
    .io_master_awid(io_master_awid), .io_master_awaddr(io_master_awaddr),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wready(io_master_wready), .io_master_wvalid(io_master_wvalid),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
    .io_master_arid(io_master_arid), .io_master_araddr(io_master_araddr),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rready(io_master_rready), .io_master_rvalid(io_master_rvalid),
    .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream handshake counters (to prove a single AW and a single W).
  always @(posedge clock) begin
    if (io_master_awvalid && io_master_awready) aw_cnt++;
    if (io_master_wvalid && io_master_wready) w_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end else begin
      $display("ok   %s = %b", name, act);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endtask

  // stim = {ifu_arvalid, lsu_arvalid, m_arready, m_rvalid, m_rlast, ifu_rready, lsu_rready}
  // expv = {ifu_arready, lsu_arready, m_arvalid, ifu_rvalid, lsu_rvalid, m_rready}
  typedef struct packed {
    logic [6:0]  stim;
    logic [5:0]  expv;
    logic [3:0]  e_id;
    logic [31:0] e_addr;
  } vec_t;

  localparam logic [31:0] IA = 32'h3000_0000;
  localparam logic [31:0] LA = 32'h8000_0100;

  vec_t tbl [16];

  initial begin
    // Tie after reset -> IFU; tie again -> LSU; then IFU; LSU alternation.
    tbl[0]  = '{7'b1100000, 6'b100000, 4'd0, 32'd0};
    tbl[1]  = '{7'b0110000, 6'b001000, 4'd0, IA};
    tbl[2]  = '{7'b0101111, 6'b000101, 4'd0, 32'd0};
    tbl[3]  = '{7'b1100000, 6'b010000, 4'd0, 32'd0};
    tbl[4]  = '{7'b1000000, 6'b001000, 4'd1, LA};
    tbl[5]  = '{7'b1010000, 6'b001000, 4'd1, LA};
    tbl[6]  = '{7'b1001001, 6'b000011, 4'd0, 32'd0};
    tbl[7]  = '{7'b1001100, 6'b000010, 4'd0, 32'd0};
    tbl[8]  = '{7'b1001101, 6'b000011, 4'd0, 32'd0};
    tbl[9]  = '{7'b1100000, 6'b100000, 4'd0, 32'd0};
    tbl[10] = '{7'b0110000, 6'b001000, 4'd0, IA};
    tbl[11] = '{7'b0101110, 6'b000101, 4'd0, 32'd0};
    tbl[12] = '{7'b0100000, 6'b010000, 4'd0, 32'd0};
    tbl[13] = '{7'b0010000, 6'b001000, 4'd1, LA};
    tbl[14] = '{7'b0001101, 6'b000011, 4'd0, 32'd0};
    tbl[15] = '{7'b0000000, 6'b000000, 4'd0, 32'd0};

    reset = 1'b0;
    ifu_arvalid = 0; ifu_araddr = IA; ifu_arlen = 0; ifu_arsize = 3'd2; ifu_arburst = 2'b01;
    ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = LA; lsu_arlen = 0; lsu_arsize = 3'd2; lsu_arburst = 2'b01;
    lsu_rready = 0;
    lsu_awvalid = 0; lsu_awaddr = 0; lsu_awlen = 0; lsu_awsize = 3'd2; lsu_awburst = 2'b01;
    lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 0; lsu_bready = 0;
    io_master_awready = 0; io_master_wready = 0;
    io_master_bvalid = 0; io_master_bresp = 0; io_master_bid = 0;
    io_master_arready = 0; io_master_rvalid = 0; io_master_rresp = 0;
    io_master_rdata = 32'h0000_0413; io_master_rlast = 0; io_master_rid = 0;

    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    settle();
    // Reset state
    chk1("rst m_arvalid", io_master_arvalid, 1'b0);
    chk1("rst m_awvalid", io_master_awvalid, 1'b0);
    chk1("rst m_rready", io_master_rready, 1'b0);
    chk1("rst m_bready", io_master_bready, 1'b0);
    chk1("rst ifu_rvalid", ifu_rvalid, 1'b0);
    chk1("rst lsu_bvalid", lsu_bvalid, 1'b0);
    chk1("rst ifu_arready", ifu_arready, 1'b0);
    chk32("rst araddr", io_master_araddr, 32'd0);
    chk32("rst arid", 32'(io_master_arid), 32'd0);
    tick();

    // Table-driven read/arbitration vectors
    for (int i = 0; i < 16; i++) begin
      {ifu_arvalid, lsu_arvalid, io_master_arready, io_master_rvalid,
       io_master_rlast, ifu_rready, lsu_rready} = tbl[i].stim;
      settle();
      chk1($sformatf("v%0d ifu_arready", i), ifu_arready, tbl[i].expv[5]);
      chk1($sformatf("v%0d lsu_arready", i), lsu_arready, tbl[i].expv[4]);
      chk1($sformatf("v%0d m_arvalid", i), io_master_arvalid, tbl[i].expv[3]);
      chk1($sformatf("v%0d ifu_rvalid", i), ifu_rvalid, tbl[i].expv[2]);
      chk1($sformatf("v%0d lsu_rvalid", i), lsu_rvalid, tbl[i].expv[1]);
      chk1($sformatf("v%0d m_rready", i), io_master_rready, tbl[i].expv[0]);
      if (tbl[i].expv[3]) begin
        chk32($sformatf("v%0d arid", i), 32'(io_master_arid), 32'(tbl[i].e_id));
        chk32($sformatf("v%0d araddr", i), io_master_araddr, tbl[i].e_addr);
      end
      tick();
    end
    {ifu_arvalid, lsu_arvalid, io_master_arready, io_master_rvalid,
     io_master_rlast, ifu_rready, lsu_rready} = 7'b0;

    // LSU write: W accepted two cycles before AWREADY
    begin
      int aw0, w0;
      aw0 = aw_cnt; w0 = w_cnt;
      lsu_awvalid = 1; lsu_awaddr = 32'h8000_0010;
      lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wlast = 1;
      settle();
      chk1("wr grant lsu_awready", lsu_awready, 1'b1);
      chk1("wr idle m_wvalid", io_master_wvalid, 1'b0);
      tick();
      lsu_awvalid = 0; io_master_wready = 1;
      settle();
      chk1("wr m_awvalid", io_master_awvalid, 1'b1);
      chk32("wr awaddr", io_master_awaddr, 32'h8000_0010);
      chk32("wr awid", 32'(io_master_awid), 32'd1);
      chk32("wr awlen/size/burst", 32'({io_master_awlen, io_master_awsize, io_master_awburst}),
            32'({8'd0, 3'd2, 2'b01}));
      chk1("wr m_wvalid", io_master_wvalid, 1'b1);
      chk1("wr lsu_wready", lsu_wready, 1'b1);
      chk32("wr wdata", io_master_wdata, 32'hDEAD_BEEF);
      chk32("wr wstrb/wlast", 32'({io_master_wstrb, io_master_wlast}), 32'h1F);
      tick();
      settle();
      chk1("wr w blocked m_wvalid", io_master_wvalid, 1'b0);
      chk1("wr w blocked lsu_wready", lsu_wready, 1'b0);
      chk1("wr aw held", io_master_awvalid, 1'b1);
      tick();
      lsu_wvalid = 0; io_master_wready = 0; io_master_awready = 1;
      settle();
      chk1("wr aw held 2", io_master_awvalid, 1'b1);
      tick();
      io_master_awready = 0; lsu_bready = 1;
      settle();
      chk1("wrb m_awvalid", io_master_awvalid, 1'b0);
      chk1("wrb m_bready", io_master_bready, 1'b1);
      chk1("wrb lsu_bvalid early", lsu_bvalid, 1'b0);
      tick();
      io_master_bvalid = 1; io_master_bresp = 2'b00;
      settle();
      chk1("wrb lsu_bvalid", lsu_bvalid, 1'b1);
      chk32("wrb lsu_bresp", 32'(lsu_bresp), 32'd0);
      tick();
      io_master_bvalid = 0; lsu_bready = 0;
      settle();
      chk1("wr done lsu_bvalid", lsu_bvalid, 1'b0);
      chk32("wr single AW", 32'(aw_cnt - aw0), 32'd1);
      chk32("wr single W", 32'(w_cnt - w0), 32'd1);
    end

    // Simultaneous AW and W handshake -> straight to WR_B
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0020;
    lsu_wvalid = 1; lsu_wdata = 32'h1234_5678; lsu_wlast = 1;
    settle();
    chk1("sim grant lsu_awready", lsu_awready, 1'b1);
    tick();
    lsu_awvalid = 0; io_master_awready = 1; io_master_wready = 1;
    settle();
    chk1("sim m_awvalid", io_master_awvalid, 1'b1);
    chk1("sim m_wvalid", io_master_wvalid, 1'b1);
    tick();
    lsu_wvalid = 0; io_master_awready = 0; io_master_wready = 0;
    lsu_bready = 1; io_master_bvalid = 1;
    settle();
    chk1("sim lsu_bvalid", lsu_bvalid, 1'b1);
    chk1("sim m_awvalid off", io_master_awvalid, 1'b0);
    tick();
    io_master_bvalid = 0; lsu_bready = 0;

    // IFU 4-beat burst with a stall on beat 2, LSU AR pending
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0040; ifu_arlen = 8'd3;
    settle();
    chk1("burst grant ifu_arready", ifu_arready, 1'b1);
    tick();
    ifu_arvalid = 0; lsu_arvalid = 1; lsu_araddr = 32'h8000_0200;
    io_master_arready = 1;
    settle();
    chk32("burst arlen", 32'(io_master_arlen), 32'd3);
    chk1("burst lsu waits", lsu_arready, 1'b0);
    tick();
    io_master_arready = 0;
    for (int b = 0; b < 4; b++) begin
      io_master_rvalid = 1; io_master_rdata = 32'h1000 + 32'(b); io_master_rlast = (b == 3);
      if (b == 2) begin
        ifu_rready = 0;
        settle();
        chk1("burst stall ifu_rvalid", ifu_rvalid, 1'b1);
        chk1("burst stall m_rready", io_master_rready, 1'b0);
        tick();
      end
      ifu_rready = 1;
      settle();
      chk32($sformatf("burst beat%0d rdata", b), ifu_rdata, 32'h1000 + 32'(b));
      chk1($sformatf("burst beat%0d m_rready", b), io_master_rready, 1'b1);
      chk1($sformatf("burst beat%0d lsu_arready", b), lsu_arready, 1'b0);
      tick();
    end
    io_master_rvalid = 0; io_master_rlast = 0; ifu_rready = 0;
    settle();
    chk1("burst idle grants lsu", lsu_arready, 1'b1);
    chk1("burst idle ifu_rvalid", ifu_rvalid, 1'b0);
    tick();
    lsu_arvalid = 0;
    settle();
    chk1("lsu rd m_arvalid", io_master_arvalid, 1'b1);
    chk32("lsu rd arid", 32'(io_master_arid), 32'd1);
    chk32("lsu rd araddr", io_master_araddr, 32'h8000_0200);
    io_master_arready = 1;
    tick();
    io_master_arready = 0;

    // Error response passes through unchanged
    io_master_rvalid = 1; io_master_rlast = 1; io_master_rresp = 2'b10;
    io_master_rdata = 32'hBAD0_0BAD; lsu_rready = 1;
    settle();
    chk1("err lsu_rvalid", lsu_rvalid, 1'b1);
    chk32("err lsu_rresp", 32'(lsu_rresp), 32'd2);
    chk32("err lsu_rdata", lsu_rdata, 32'hBAD0_0BAD);
    chk1("err lsu_rlast", lsu_rlast, 1'b1);
    chk1("err ifu_rvalid", ifu_rvalid, 1'b0);
    tick();
    io_master_rvalid = 0; io_master_rlast = 0; io_master_rresp = 0; lsu_rready = 0;
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0080; ifu_arlen = 0;
    settle();
    chk1("err back to idle", ifu_arready, 1'b1);
    tick();
    ifu_arvalid = 0; io_master_arready = 1;
    tick();
    io_master_arready = 0;

    // Asynchronous reset during RD_R
    io_master_rvalid = 1; ifu_rready = 1;
    settle();
    chk1("pre-rst ifu_rvalid", ifu_rvalid, 1'b1);
    chk1("pre-rst m_rready", io_master_rready, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("async rst ifu_rvalid", ifu_rvalid, 1'b0);
    chk1("async rst m_rready", io_master_rready, 1'b0);
    chk1("async rst m_arvalid", io_master_arvalid, 1'b0);
    chk32("async rst araddr", io_master_araddr, 32'd0);
    io_master_rvalid = 0; ifu_rready = 0;
    tick();
    reset = 1'b1;

    // Lone IFU read after reset release
    io_master_arready = 1;
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; ifu_arlen = 0;
    io_master_rdata = 32'h0000_0413;
    settle();
    chk1("lone grant", ifu_arready, 1'b1);
    tick();
    ifu_arvalid = 0;
    settle();
    chk1("lone m_arvalid", io_master_arvalid, 1'b1);
    chk32("lone arid", 32'(io_master_arid), 32'd0);
    chk32("lone araddr", io_master_araddr, 32'h3000_0000);
    chk32("lone arlen/size/burst", 32'({io_master_arlen, io_master_arsize, io_master_arburst}),
          32'({8'd0, 3'd2, 2'b01}));
    tick();
    io_master_rvalid = 1; io_master_rlast = 1; ifu_rready = 1;
    settle();
    chk1("lone ifu_rvalid", ifu_rvalid, 1'b1);
    chk32("lone ifu_rdata", ifu_rdata, 32'h0000_0413);
    chk32("lone ifu_rresp/rlast", 32'({ifu_rresp, ifu_rlast}), 32'd1);
    chk1("lone lsu_rvalid", lsu_rvalid, 1'b0);
    tick();
    io_master_rvalid = 0; io_master_rlast = 0; ifu_rready = 0; io_master_arready = 0;
    settle();
    chk1("lone done ifu_rvalid", ifu_rvalid, 1'b0);
    chk1("lone done m_arvalid", io_master_arvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
